// File: rtl/uart_beep_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : uart_beep_cmd
//  Description : 8N1 UART receiver with mid-bit sampling, single-byte command
//                decoder and auto-release hold timer that drives the buzzer
//                enable level (beep_flag) for the downstream buzzer stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_beep_cmd #(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         BAUD        = 9600,
  parameter logic [7:0] CMD_ON      = 8'h42,
  parameter logic [7:0] CMD_OFF     = 8'h53,
  parameter int         HOLD_CYCLES = 150_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic       beep_flag,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  // Bit timing: the baud counter spans one bit period, sampling at its middle.
  localparam int C_BIT_MAX = CLK_FREQ / BAUD - 1;
  localparam int C_MID     = C_BIT_MAX / 2;
  localparam int C_BAUD_W  = (C_BIT_MAX > 0) ? $clog2(C_BIT_MAX + 1) : 1;

  localparam logic [C_BAUD_W-1:0] C_BIT_MAX_V = C_BAUD_W'(C_BIT_MAX);
  localparam logic [C_BAUD_W-1:0] C_MID_V     = C_BAUD_W'(C_MID);
  localparam logic [C_BAUD_W-1:0] C_BAUD_ONE  = C_BAUD_W'(1);

  // Hold timer: a zero hold length disables the auto-release entirely.
  localparam bit          C_HOLD_EN   = (HOLD_CYCLES != 0);
  localparam logic [27:0] C_HOLD_LAST = (HOLD_CYCLES == 0) ? 28'd0 : 28'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                r_rx_sync1;
  logic                r_rx_sync2;
  logic                r_rx_prev;
  state_t              r_state;
  logic [C_BAUD_W-1:0] r_baud_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [27:0]         r_hold_cnt;
  logic                r_retrig;

  logic w_rx_fall;
  logic w_cmd_on;
  logic w_cmd_off;

  // A start bit shows up as a synchronized high-to-low transition.
  assign w_rx_fall = r_rx_prev & ~r_rx_sync2;
  assign w_cmd_on  = rx_valid && (rx_data == CMD_ON);
  assign w_cmd_off = rx_valid && (rx_data == CMD_OFF);

  // Bring the asynchronous line into the clock domain and keep one cycle of history.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= rx;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  // Receiver FSM: frame the byte, sample each bit at its midpoint, raise strobes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= 3'd0;
          if (w_rx_fall) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if ((r_baud_cnt == C_MID_V) && r_rx_sync2) begin
            // Line went back high before mid-bit: treat as a glitch.
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
          end else if (r_baud_cnt == C_BIT_MAX_V) begin
            r_state    <= S_DATA;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
          end else begin
            r_baud_cnt <= r_baud_cnt + C_BAUD_ONE;
          end
        end
        S_DATA: begin
          if (r_baud_cnt == C_MID_V) begin
            r_shift <= {r_rx_sync2, r_shift[7:1]};
          end
          if (r_baud_cnt == C_BIT_MAX_V) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + C_BAUD_ONE;
          end
        end
        S_STOP: begin
          if (r_baud_cnt == C_MID_V) begin
            // Leave at mid-stop so a start bit right after one stop bit is caught.
            if (r_rx_sync2) begin
              rx_data  <= r_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + C_BAUD_ONE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= '0;
        end
      endcase
    end
  end

  // Command decode and hold timer; a received command beats a same-cycle timeout.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beep_flag  <= 1'b0;
      r_hold_cnt <= 28'd0;
      r_retrig   <= 1'b0;
    end else if (w_cmd_on) begin
      r_hold_cnt <= 28'd0;
      if (beep_flag) begin
        // One low cycle tells the buzzer stage to restart its tone and duration.
        beep_flag <= 1'b0;
        r_retrig  <= 1'b1;
      end else begin
        beep_flag <= 1'b1;
        r_retrig  <= 1'b0;
      end
    end else if (w_cmd_off) begin
      beep_flag  <= 1'b0;
      r_hold_cnt <= 28'd0;
      r_retrig   <= 1'b0;
    end else if (r_retrig) begin
      beep_flag  <= 1'b1;
      r_hold_cnt <= 28'd0;
      r_retrig   <= 1'b0;
    end else if (beep_flag && C_HOLD_EN) begin
      if (r_hold_cnt == C_HOLD_LAST) begin
        beep_flag  <= 1'b0;
        r_hold_cnt <= 28'd0;
      end else begin
        r_hold_cnt <= r_hold_cnt + 28'd1;
      end
    end else begin
      r_hold_cnt <= 28'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_beep_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_beep_cmd
//  Description : Self-checking bench for uart_beep_cmd. Drives serial frames,
//                glitches and resets; a reference model predicts the byte
//                stream, strobe timing window and beep_flag level per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_beep_cmd;

  localparam int         CLK_FREQ = 1_600_000;
  localparam int         BAUD     = 100_000;
  localparam int         BIT_N    = CLK_FREQ / BAUD;   // clocks per bit
  localparam int         HOLD     = 1000;
  localparam logic [7:0] CMD_ON   = 8'h42;
  localparam logic [7:0] CMD_OFF  = 8'h53;
  // Strobe expected roughly 9.5 bit times after the start edge.
  localparam int         LAT_LO   = 9 * BIT_N + BIT_N / 2 - 4;
  localparam int         LAT_HI   = 9 * BIT_N + BIT_N / 2 + 6;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       rx;
  logic       beep_flag;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  uart_beep_cmd #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .CMD_ON     (CMD_ON),
    .CMD_OFF    (CMD_OFF),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx       (rx),
    .beep_flag(beep_flag),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: queue of expected frames plus the beep "on" interval.
  typedef struct {
    logic [7:0] data;
    logic       err;
    int         t0;
  } exp_t;

  exp_t       exp_q[$];
  int         hf = 1;          // first cycle beep_flag is expected high
  int         ht = 0;          // last cycle beep_flag is expected high
  logic [7:0] last_data = 8'h00;

  always @(negedge sys_clk) begin
    logic exp_beep;
    exp_t e;
    exp_beep = (cyc >= hf) && (cyc <= ht);
    chk("beep_flag", beep_flag, exp_beep);
    chk("strobe_excl", rx_valid & frame_err, 0);
    if (rx_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", {rx_valid, frame_err}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", frame_err, e.err);
        chk("strobe_time", (cyc >= e.t0 + LAT_LO) && (cyc <= e.t0 + LAT_HI), 1);
        if (!e.err) begin
          chk("rx_data", rx_data, e.data);
          last_data = e.data;
          if (e.data == CMD_ON) begin
            hf = exp_beep ? cyc + 2 : cyc + 1;
            ht = hf + HOLD - 1;
          end else if (e.data == CMD_OFF) begin
            if (ht > cyc) ht = cyc;
          end
        end else begin
          chk("rx_data_keep", rx_data, last_data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Drives one frame starting now; optionally resets the DUT from mid data
  // bit 4 until mid stop bit, in which case no strobe is expected.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input bit do_rst);
    logic [9:0] bits;
    bits = {stop_ok, d, 1'b0};
    if (!do_rst) exp_q.push_back('{d, !stop_ok, cyc});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < BIT_N; j++) begin
        if (do_rst && i == 5 && j == BIT_N / 2) begin
          hf = 1;
          ht = 0;
          exp_q.delete();
          last_data = 8'h00;
          sys_rst_n = 1'b0;
          #1;
          chk("rst_beep", beep_flag, 0);
          chk("rst_valid", rx_valid, 0);
          chk("rst_ferr", frame_err, 0);
          chk("rst_data", rx_data, 0);
        end
        if (do_rst && i == 9 && j == BIT_N / 2) sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
      end
    end
    rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    idle(len);
    rx = 1'b1;
    idle(3 * BIT_N);
  endtask

  initial begin
    logic [7:0] d;
    logic       ok;
    int         r;
    sys_rst_n = 1'b0;
    rx        = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_beep", beep_flag, 0);
    chk("reset_valid", rx_valid, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_data", rx_data, 0);
    sys_rst_n = 1'b1;
    idle(1000);

    // Basic on / off
    send_frame(CMD_ON, 1'b1, 1'b0);
    idle(50);
    send_frame(CMD_OFF, 1'b1, 1'b0);
    idle(50);

    // Timeout, then retrigger part-way through the hold
    send_frame(CMD_ON, 1'b1, 1'b0);
    idle(HOLD + 100);
    send_frame(CMD_ON, 1'b1, 1'b0);
    idle(340);
    send_frame(CMD_ON, 1'b1, 1'b0);
    idle(HOLD + 200);

    // Framing error keeps old data and beep state
    send_frame(8'h55, 1'b0, 1'b0);
    idle(40);

    // Short glitches on the idle line
    for (int g = 0; g < 3; g++) glitch($urandom_range(1, 5));

    // Back-to-back frames with a single stop bit
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(CMD_ON, 1'b1, 1'b0);
    idle(20);

    // Reset in the middle of a frame while beeping, then a clean frame
    send_frame(CMD_ON, 1'b1, 1'b1);
    idle(20);
    send_frame(CMD_ON, 1'b1, 1'b0);
    idle(50);

    // Randomized command traffic
    for (int k = 0; k < 16; k++) begin
      r  = $urandom_range(0, 9);
      d  = (r < 3) ? CMD_ON : (r < 5) ? CMD_OFF : 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, 1'b0);
      if (!ok)                           idle($urandom_range(20, 60));
      else if ($urandom_range(0, 3) == 0) idle($urandom_range(900, 1200));
      else                                idle($urandom_range(0, 60));
    end

    idle(HOLD + 200);
    chk("pending_frames", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
